// File: rtl/codec_pkg.sv
// Shared codec-link definitions: default serial timing and the receive FSM states.
// The DAC transmit path uses the same timing constants so both paths share one frame.
package codec_pkg;

  localparam int DATA_W_DEF   = 24;
  localparam int SLOT_CNT_DEF = 25;
  localparam int BCLK_LO_DEF  = 2;
  localparam int BCLK_HI_DEF  = 3;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_LEFT  = 2'd2,
    RX_RIGHT = 2'd3
  } rx_state_t;

endpackage

// File: rtl/codec_adc_rx_if.sv
// Stereo sample-pair stream from the ADC receiver to the DSP/FIR chain.
// Handshake: a pair transfers on any cycle with o_valid & i_ready; o_left/o_right stay stable
// while o_valid is high unless the producer overwrites them with a newer pair.
interface codec_adc_rx_if #(
  parameter int DATA_W = codec_pkg::DATA_W_DEF
) ();

  logic [DATA_W-1:0] o_left;
  logic [DATA_W-1:0] o_right;
  logic              o_valid;
  logic              i_ready;

  modport master (output o_left, output o_right, output o_valid, input i_ready);
  modport slave  (input o_left, input o_right, input o_valid, output i_ready);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta <= 1'b0;
      o_q  <= 1'b0;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/codec_adc_rx.sv
// Master-mode codec ADC receiver: generates BCLK/ADCLRCK from MCLK, deserialises ADCDAT
// into left/right samples and offers each stereo pair on a valid/ready stream.
module codec_adc_rx
  import codec_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SLOT_CNT   = SLOT_CNT_DEF,
  parameter int BCLK_LO    = BCLK_LO_DEF,
  parameter int BCLK_HI    = BCLK_HI_DEF,
  parameter int DATA_DELAY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_config_done,
  input  logic                  i_adc_dat,
  input  logic                  i_ovr_clr,
  output logic                  o_bclk,
  output logic                  o_adclrck,
  output logic                  o_overrun,
  output rx_state_t             o_state,
  codec_adc_rx_if.master        rx
);

  localparam int PH_W    = $clog2(BCLK_LO + BCLK_HI);
  localparam int SL_W    = $clog2(SLOT_CNT);
  localparam int PH_LAST = BCLK_LO + BCLK_HI - 1;
  localparam logic [SL_W:0] CAP_LO = (SL_W+1)'(DATA_DELAY);
  localparam logic [SL_W:0] CAP_HI = (SL_W+1)'(DATA_DELAY + DATA_W);

  rx_state_t         state, state_nxt;
  logic [PH_W-1:0]   phase;
  logic [SL_W-1:0]   slot;
  logic [SL_W-1:0]   s_idx;
  logic              adc_sync;
  logic              last_phase, half_end, cap_slot, shift_en, publish;
  logic [DATA_W-1:0] shreg, shreg_nxt, left_hold;
  logic [DATA_W-1:0] left_q, right_q;
  logic              valid_q, ovr_q;

  sync_2ff u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_adc_dat),
    .o_q   (adc_sync)
  );

  // slot counts down; s_idx is the slot number counted up from the LRCK edge
  assign s_idx      = SL_W'(SLOT_CNT - 1) - slot;
  assign last_phase = (phase == PH_W'(PH_LAST));
  assign half_end   = last_phase && (slot == '0);
  assign cap_slot   = (({1'b0, s_idx} + (SL_W+1)'(1)) > CAP_LO) && ({1'b0, s_idx} < CAP_HI);
  assign shift_en   = ((state == RX_LEFT) || (state == RX_RIGHT)) && last_phase && cap_slot;
  assign shreg_nxt  = shift_en ? {shreg[DATA_W-2:0], adc_sync} : shreg;
  assign publish    = (state == RX_RIGHT) && half_end;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= RX_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_bclk    = 1'b1;
    o_adclrck = 1'b0;
    case (state)
      RX_IDLE:  if (i_config_done) state_nxt = RX_START;
      RX_START: state_nxt = RX_LEFT;
      RX_LEFT: begin
        o_bclk    = (phase >= PH_W'(BCLK_LO));
        o_adclrck = 1'b1;
        if (half_end) state_nxt = RX_RIGHT;
      end
      RX_RIGHT: begin
        o_bclk = (phase >= PH_W'(BCLK_LO));
        if (half_end) state_nxt = RX_LEFT;
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      phase <= '0;
      slot  <= '0;
    end else begin
      case (state)
        RX_START: begin
          phase <= '0;
          slot  <= SL_W'(SLOT_CNT - 1);
        end
        RX_LEFT, RX_RIGHT: begin
          if (last_phase) begin
            phase <= '0;
            slot  <= (slot == '0) ? SL_W'(SLOT_CNT - 1) : slot - 1'b1;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        default: begin
          phase <= '0;
          slot  <= '0;
        end
      endcase
    end
  end

  // left_hold and the published right word both include the final shift of their half-frame
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      shreg     <= '0;
      left_hold <= '0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      shreg <= shreg_nxt;
      if ((state == RX_LEFT) && half_end) left_hold <= shreg_nxt;
      if (publish) begin
        left_q  <= left_hold;
        right_q <= shreg_nxt;
        valid_q <= 1'b1;
      end else if (valid_q && rx.i_ready) begin
        valid_q <= 1'b0;
      end
      if (publish && valid_q && !rx.i_ready) ovr_q <= 1'b1;
      else if (i_ovr_clr)                     ovr_q <= 1'b0;
    end
  end

  assign rx.o_left  = left_q;
  assign rx.o_right = right_q;
  assign rx.o_valid = valid_q;
  assign o_overrun  = ovr_q;
  assign o_state    = state;

endmodule

// File: tb/tb_codec_adc_rx.sv
// Directed bench for codec_adc_rx: I2S build (a) and left-justified build (b), each fed by
// a loopback codec model that launches ADCDAT on BCLK falling edges.
module tb_codec_adc_rx;
  import codec_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic      cfg_a, cfg_b, adc_a, adc_b, ovr_clr;
  logic      bclk_a, lrck_a, ovr_a, bclk_b, lrck_b, ovr_b;
  rx_state_t st_a, st_b;

  codec_adc_rx_if #(.DATA_W(24)) if_a ();
  codec_adc_rx_if #(.DATA_W(24)) if_b ();

  codec_adc_rx #(.DATA_DELAY(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_config_done(cfg_a), .i_adc_dat(adc_a), .i_ovr_clr(ovr_clr),
    .o_bclk(bclk_a), .o_adclrck(lrck_a), .o_overrun(ovr_a), .o_state(st_a), .rx(if_a)
  );

  codec_adc_rx #(.DATA_DELAY(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_config_done(cfg_b), .i_adc_dat(adc_b), .i_ovr_clr(ovr_clr),
    .o_bclk(bclk_b), .o_adclrck(lrck_b), .o_overrun(ovr_b), .o_state(st_b), .rx(if_b)
  );

  // scoreboard
  logic [23:0] exp_l_q[$], exp_r_q[$];
  logic [23:0] lq_a[$], rq_a[$], lq_b[$], rq_b[$];
  int checks = 0;
  int errors = 0;

  function automatic logic codec_bit(input logic [23:0] w, input int s, input int dd);
    int k;
    k = s - dd;
    if (k >= 0 && k < 24) return w[23-k];
    return 1'b0;
  endfunction

  // codec model, I2S (one slot delay)
  initial begin
    logic pb, pl;
    int sl;
    logic [23:0] cl, cr;
    pb = 1'b1; pl = 1'b0; sl = 0; cl = '0; cr = '0; adc_a = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (lrck_a && !pl) begin
        cl = '0; cr = '0;
        if (lq_a.size() > 0) cl = lq_a.pop_front();
        if (rq_a.size() > 0) cr = rq_a.pop_front();
      end
      if (pb && !bclk_a) begin
        sl = (lrck_a != pl) ? 0 : sl + 1;
        adc_a = codec_bit(lrck_a ? cl : cr, sl, 1);
      end
      pb = bclk_a; pl = lrck_a;
    end
  end

  // codec model, left-justified
  initial begin
    logic pb, pl;
    int sl;
    logic [23:0] cl, cr;
    pb = 1'b1; pl = 1'b0; sl = 0; cl = '0; cr = '0; adc_b = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (lrck_b && !pl) begin
        cl = '0; cr = '0;
        if (lq_b.size() > 0) cl = lq_b.pop_front();
        if (rq_b.size() > 0) cr = rq_b.pop_front();
      end
      if (pb && !bclk_b) begin
        sl = (lrck_b != pl) ? 0 : sl + 1;
        adc_b = codec_bit(lrck_b ? cl : cr, sl, 0);
      end
      pb = bclk_b; pl = lrck_b;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_lrck(input bit use_b, input logic lvl, input string tag);
    logic prev, cur;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      prev = use_b ? lrck_b : lrck_a;
      step();
      cur = use_b ? lrck_b : lrck_a;
      if (prev != lvl && cur == lvl) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $error("FAIL %s observed=timeout expected=lrck edge to %0b", tag, lvl);
    end
  endtask

  task automatic push_a(input logic [23:0] l, input logic [23:0] r);
    lq_a.push_back(l); rq_a.push_back(r);
    exp_l_q.push_back(l); exp_r_q.push_back(r);
  endtask

  task automatic chk_pair_a(input string tag);
    logic [23:0] el, er;
    el = exp_l_q.pop_front();
    er = exp_r_q.pop_front();
    chk({tag, "_left"}, 32'(if_a.o_left), 32'(el));
    chk({tag, "_right"}, 32'(if_a.o_right), 32'(er));
  endtask

  task automatic accept_a();
    if_a.i_ready = 1'b1;
    step();
    if_a.i_ready = 1'b0;
  endtask

  // directed sequence
  initial begin
    int hi, lo, early, bad;
    rst = 1'b1; cfg_a = 1'b0; cfg_b = 1'b0; ovr_clr = 1'b0;
    if_a.i_ready = 1'b0; if_b.i_ready = 1'b0;
    step(); step();

    chk("rst_bclk", 32'(bclk_a), 32'd1);
    chk("rst_lrck", 32'(lrck_a), 32'd0);
    chk("rst_left", 32'(if_a.o_left), 32'd0);
    chk("rst_right", 32'(if_a.o_right), 32'd0);
    chk("rst_valid", 32'(if_a.o_valid), 32'd0);
    chk("rst_ovr", 32'(ovr_a), 32'd0);
    chk("rst_state", 32'(st_a), 32'(RX_IDLE));
    chk("rst_b_bclk", 32'(bclk_b), 32'd1);

    // frames 0..7 for build a: fixed pair, 4 random, 2 backpressure, 1 simultaneous
    push_a(24'hA5A5A5, 24'h123456);
    for (int f = 1; f < 8; f++) push_a(24'($urandom()), 24'($urandom()));

    rst = 1'b0;
    step(); step(); step();
    chk("idle_state", 32'(st_a), 32'(RX_IDLE));
    chk("idle_bclk", 32'(bclk_a), 32'd1);

    cfg_a = 1'b1;
    step();
    chk("start_state", 32'(st_a), 32'(RX_START));
    chk("start_bclk", 32'(bclk_a), 32'd1);
    chk("start_lrck", 32'(lrck_a), 32'd0);
    step();
    chk("left_state", 32'(st_a), 32'(RX_LEFT));
    // first slot: 2 low, 3 high
    for (int k = 0; k < 5; k++) begin
      chk("bclk_shape", 32'(bclk_a), (k >= 2) ? 32'd1 : 32'd0);
      chk("lrck_left", 32'(lrck_a), 32'd1);
      step();
    end
    hi = 0;
    while (lrck_a && hi < 400) begin hi++; step(); end
    chk("lrck_high_rest", 32'(hi), 32'd120);
    lo = 0; early = 0;
    while (!lrck_a && lo < 400) begin
      if (if_a.o_valid) early++;
      lo++; step();
    end
    chk("lrck_low_len", 32'(lo), 32'd125);
    chk("valid_early", 32'(early), 32'd0);
    chk("valid_latency", 32'(if_a.o_valid), 32'd1);
    chk_pair_a("loop0");
    accept_a();
    chk("hs_clear", 32'(if_a.o_valid), 32'd0);

    for (int f = 1; f <= 4; f++) begin
      wait_lrck(1'b0, 1'b1, "frame");
      chk("rand_valid", 32'(if_a.o_valid), 32'd1);
      chk_pair_a("rand");
      accept_a();
      chk("rand_clear", 32'(if_a.o_valid), 32'd0);
    end

    // backpressure over two publishes
    wait_lrck(1'b0, 1'b1, "bp1");
    chk("bp1_valid", 32'(if_a.o_valid), 32'd1);
    chk("bp1_ovr", 32'(ovr_a), 32'd0);
    chk_pair_a("bp1");
    wait_lrck(1'b0, 1'b1, "bp2");
    chk("bp2_valid", 32'(if_a.o_valid), 32'd1);
    chk("bp2_ovr", 32'(ovr_a), 32'd1);
    chk_pair_a("bp2");
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("ovr_clr", 32'(ovr_a), 32'd0);
    chk("ovr_clr_valid", 32'(if_a.o_valid), 32'd1);

    // i_ready high exactly in the last RIGHT cycle (125 cycles after the falling LRCK edge)
    wait_lrck(1'b0, 1'b0, "sim_fall");
    for (int k = 0; k < 124; k++) step();
    accept_a();
    chk("sim_state", 32'(st_a), 32'(RX_LEFT));
    chk("sim_valid", 32'(if_a.o_valid), 32'd1);
    chk("sim_ovr", 32'(ovr_a), 32'd0);
    chk_pair_a("sim");

    // reset at slot 10 of LEFT (50 MCLK into the half-frame)
    for (int k = 0; k < 50; k++) step();
    chk("pre_rst_valid", 32'(if_a.o_valid), 32'd1);
    chk("pre_rst_bclk", 32'(bclk_a), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_bclk", 32'(bclk_a), 32'd1);
    chk("mid_rst_lrck", 32'(lrck_a), 32'd0);
    chk("mid_rst_valid", 32'(if_a.o_valid), 32'd0);
    chk("mid_rst_left", 32'(if_a.o_left), 32'd0);
    chk("mid_rst_right", 32'(if_a.o_right), 32'd0);
    chk("mid_rst_ovr", 32'(ovr_a), 32'd0);
    chk("mid_rst_state", 32'(st_a), 32'(RX_IDLE));
    step(); step();
    lq_a.delete(); rq_a.delete();
    push_a(24'h7FFFFF, 24'h800000);
    rst = 1'b0;
    wait_lrck(1'b0, 1'b1, "post_rst_start");
    wait_lrck(1'b0, 1'b1, "post_rst_pub");
    chk("post_rst_valid", 32'(if_a.o_valid), 32'd1);
    chk_pair_a("post_rst");

    // build b was never enabled
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      if (bclk_b !== 1'b1 || lrck_b !== 1'b0) bad++;
      step();
    end
    chk("b_idle_hold", 32'(bad), 32'd0);
    chk("b_idle_state", 32'(st_b), 32'(RX_IDLE));

    lq_b.push_back(24'h000001); rq_b.push_back(24'hFFFFFF);
    cfg_b = 1'b1;
    wait_lrck(1'b1, 1'b1, "b_start");
    wait_lrck(1'b1, 1'b1, "b_pub");
    chk("b_valid", 32'(if_b.o_valid), 32'd1);
    chk("b_left", 32'(if_b.o_left), 32'h000001);
    chk("b_right", 32'(if_b.o_right), 32'hFFFFFF);
    chk("b_ovr", 32'(ovr_b), 32'd0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
